// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbitrated mux: state
// encoding, requester count and the round-robin winner search.
package mux4_rr_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // First set request bit, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // Returns ptr when nothing is requesting; callers gate on |req.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                           input logic [1:0]      ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4b.sv
// Plain 4:1 data mux; s selects which of d0..d3 drives y.
module mux4b #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    // Steer the selected input to the output.
    always_comb begin
        y = d0;
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
// A grant lasts up to MAX_BURST accepted beats, ends early when the granted
// requester drops its request, and is always followed by one idle cycle.
// rst_n asserts asynchronously; its release is expected to be synchronous
// to clk (synchronised upstream).
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             y_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             busy
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] win_s;

    assign win_s   = rr_pick(req, ptr_q);
    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = (state_q == BUSY);
    // A beat is only offered while the granted port still requests.
    assign y_valid = busy & req[sel_q];

    mux4b #(
        .WIDTH (WIDTH)
    ) u_mux (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s  (sel_q),
        .y  (y)
    );

    // Arbitration state, grant, select, priority pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            ptr_q      <= 2'd0;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state: grant the round-robin winner from IDLE; in BUSY count
    // accepted beats, release on the last beat or when the request drops.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = BUSY;
                    gnt_d      = onehot4(win_s);
                    sel_d      = win_s;
                    beat_cnt_d = 4'd0;
                end else begin
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                if (!req[sel_q]) begin
                    // Abort: no beat this cycle, hand priority onward.
                    state_d    = IDLE;
                    gnt_d      = 4'b0000;
                    ptr_d      = sel_q + 2'd1;
                    beat_cnt_d = 4'd0;
                end else if (y_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        gnt_d      = 4'b0000;
                        ptr_d      = sel_q + 2'd1;
                        beat_cnt_d = 4'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end else begin
                    // Backpressure: hold everything.
                    state_d    = BUSY;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = 4'b0000;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge. dut uses MAX_BURST=4, dut1
// uses MAX_BURST=1 for the full-contention rotation scenario.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d0, d1, d2, d3;
    logic       y_ready;

    logic [3:0] gnt0, gnt1;
    logic [1:0] sel0, sel1;
    logic [3:0] y0, y1;
    logic       yv0, yv1;
    logic       busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .y_ready(y_ready),
        .gnt(gnt0), .sel(sel0), .y(y0), .y_valid(yv0), .busy(busy0)
    );

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .y_ready(y_ready),
        .gnt(gnt1), .sel(sel1), .y(y1), .y_valid(yv1), .busy(busy1)
    );

    task automatic do_reset();
        req     = 4'b0000;
        y_ready = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 4'b0000 || sel0 !== 2'd0 || yv0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b sel=%0d y_valid=%b busy=%b, expected 0000 0 0 0",
                     gnt0, sel0, yv0, busy0);
        end
        checks++;
        if (y0 !== 4'h1) begin
            errors++;
            $display("FAIL reset_y: y=%h expected %h", y0, 4'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;
        // With no requests the block must stay idle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== 4'b0000 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_req[%0d]: gnt=%b busy=%b expected 0000 0", i, gnt0, busy0);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        do_reset();
        req     = 4'b0100;
        y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== exp_g[i] || yv0 !== (exp_g[i] != 4'b0000)) begin
                errors++;
                $display("FAIL single_gnt[%0d]: gnt=%b y_valid=%b expected %b %b",
                         i, gnt0, yv0, exp_g[i], exp_g[i] != 4'b0000);
            end
            if (i == 0) begin
                checks++;
                if (sel0 !== 2'd2 || y0 !== 4'hA || busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL single_data: sel=%0d y=%h busy=%b expected 2 a 1", sel0, y0, busy0);
                end
            end
        end
        // ptr is now 3: with everyone requesting, port 3 wins.
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt0 !== 4'b1000 || y0 !== 4'h4) begin
            errors++;
            $display("FAIL single_ptr_next: gnt=%b y=%h expected 1000 4", gnt0, y0);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [9];
        logic [3:0] exp_y [9];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        exp_y = '{4'h1, 4'h1, 4'h2, 4'h2, 4'hA, 4'hA, 4'h4, 4'h4, 4'h1};
        do_reset();
        req     = 4'b1111;
        y_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (gnt1 !== exp_g[i] || y1 !== exp_y[i] || yv1 !== (exp_g[i] != 4'b0000)) begin
                errors++;
                $display("FAIL contention[%0d]: gnt=%b y=%h y_valid=%b expected %b %h %b",
                         i, gnt1, y1, yv1, exp_g[i], exp_y[i], exp_g[i] != 4'b0000);
            end
        end
    endtask

    task automatic test_burst_limit();
        logic [3:0] exp_g [6];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        do_reset();
        req     = 4'b0011;
        y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== exp_g[i] || yv0 !== (exp_g[i] != 4'b0000)) begin
                errors++;
                $display("FAIL burst_limit[%0d]: gnt=%b y_valid=%b expected %b %b",
                         i, gnt0, yv0, exp_g[i], exp_g[i] != 4'b0000);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req     = 4'b0010;
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== 4'b0010 || sel0 !== 2'd1 || yv0 !== 1'b1 || busy0 !== 1'b1 || y0 !== 4'h2) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: gnt=%b sel=%0d y_valid=%b busy=%b y=%h expected 0010 1 1 1 2",
                         i, gnt0, sel0, yv0, busy0, y0);
            end
        end
        // Resume: the full burst of 4 beats must still be available.
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (gnt0 !== ((i < 3) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL backpressure_resume[%0d]: gnt=%b expected %b",
                         i, gnt0, (i < 3) ? 4'b0010 : 4'b0000);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        req     = 4'b1000;
        y_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt0 !== 4'b1000 || yv0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant: gnt=%b y_valid=%b expected 1000 1", gnt0, yv0);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        checks++;
        if (yv0 !== 1'b0 || gnt0 !== 4'b1000) begin
            errors++;
            $display("FAIL abort_no_beat: y_valid=%b gnt=%b expected 0 1000", yv0, gnt0);
        end
        @(negedge clk);
        checks++;
        if (gnt0 !== 4'b0000 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: gnt=%b busy=%b expected 0000 0", gnt0, busy0);
        end
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt0 !== 4'b0001) begin
            errors++;
            $display("FAIL abort_ptr: gnt=%b expected 0001", gnt0);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req     = 4'b0010;
        y_ready = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt0 !== 4'b0100 || y0 !== 4'hA) begin
            errors++;
            $display("FAIL midrst_grant: gnt=%b y=%h expected 0100 a", gnt0, y0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 4'b0000 || yv0 !== 1'b0 || busy0 !== 1'b0 || sel0 !== 2'd0 || y0 !== 4'h1) begin
            errors++;
            $display("FAIL midrst_async: gnt=%b y_valid=%b busy=%b sel=%0d y=%h expected 0000 0 0 0 1",
                     gnt0, yv0, busy0, sel0, y0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt0 !== 4'b0001 || y0 !== 4'h1) begin
            errors++;
            $display("FAIL midrst_ptr: gnt=%b y=%h expected 0001 1", gnt0, y0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0000;
        y_ready = 1'b0;
        d0      = 4'h1;
        d1      = 4'h2;
        d2      = 4'hA;
        d3      = 4'h4;
        test_reset();
        test_single();
        test_contention();
        test_burst_limit();
        test_backpressure();
        test_abort();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Shares one 4:1 data mux among four requesters using round-robin arbitration with a valid/ready output handshake.
- Grants one requester at a time and holds the grant for up to MAX_BURST beats, then rotates priority.
- Sits between four producer ports and a single downstream consumer; generates the mux select that steers data to the output.

Parameters:
- WIDTH, 4, data width of each input port and of y.
- MAX_BURST, 4, maximum beats transferred per grant; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request; req[i] pairs with di.
- d0, d1, d2, d3  input  WIDTH  requester data, held stable while req[i] and gnt[i] are high.
- y_ready  input  1  downstream ready.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select, registered; index of the granted requester.
- y  output  WIDTH  selected data; combinational from sel and d0..d3.
- y_valid  output  1  output beat valid.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (async assert, sync release) clears gnt=0, sel=0, y_valid=0, busy=0, ptr=0, beat_cnt=0, and sets state IDLE. y is then d0.
- ptr[1:0] is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE state:
  - If any req bit is set at edge N, the winner w is the first set bit in search order.
  - At N+1: gnt=onehot(w), sel=w, busy=1, beat_cnt=0, state BUSY.
  - Arbitration latency is one cycle.
  - If req==0, the block stays in IDLE.
- BUSY state:
  - y_valid = req[sel] (combinational, gated by busy).
  - A beat transfers on any edge where y_valid && y_ready. On each transfer, beat_cnt increments.
  - Release condition: a transfer where beat_cnt == MAX_BURST-1, or a transfer where req[sel] is low in the following cycle.
  - On release, ptr=sel+1 (wraps 3->0), gnt=0, busy=0, and state returns to IDLE. There is always one idle bubble between grants.
  - Abort: if req[sel] is low while in BUSY, no transfer occurs (y_valid=0), and the block releases on that edge with ptr=sel+1.
- Backpressure: y_ready=0 stalls the block indefinitely. gnt, sel and beat_cnt hold, and no rotation occurs.
- Requests from non-granted ports are ignored during BUSY. They stay pending and are arbitrated in the next IDLE cycle.
- beat_cnt width is 4 bits; it never exceeds MAX_BURST-1.
- Reset asserted mid-burst forces the reset values immediately. Any partial burst is discarded with no further beats.

Decomposition:
- Shared package holds:
  - state encoding IDLE=1'b0, BUSY=1'b1;
  - constant NREQ=4;
  - function rr_pick(req, ptr) returning the winner index.
- Data path instantiates the existing mux4b (WIDTH=4) as the single sub-module, with s driven by sel.
- Arbitration FSM, ptr and beat_cnt stay in the top module.

Test Plan:
- Single requester: req=4'b0100, d2=4'hA, y_ready=1 → gnt=4'b0100 one cycle later, sel=2, y=4'hA, y_valid=1. Grant is released after 4 beats, then ptr=3.
- Full contention: req=4'b1111 held, y_ready=1, MAX_BURST=1 → grant sequence 0,1,2,3,0, each separated by one IDLE cycle.
- Burst limit: req=4'b0011 held, MAX_BURST=4 → requester 0 gets exactly 4 transfers, then gnt=4'b0010 after one bubble.
- Backpressure: granted port 1, y_ready=0 for 5 cycles → gnt, sel and beat_cnt hold and y_valid=1 throughout. Transfers resume when y_ready=1.
- Abort: grant to port 3 with beat_cnt=1, then req[3] drops → no transfer that cycle, gnt=0 next cycle, ptr=0.
- Reset mid-burst: rst_n low during a grant to port 2 → gnt=0, y_valid=0, ptr=0 immediately with no clock edge. After release, req=4'b1111 grants port 0.
